// File: rtl/dla_aux_pool_pkg.sv
// Shared types and default sizing for the aux pool window scheduler.
package dla_aux_pool_pkg;

  localparam int unsigned AP_MAX_WINDOW_WIDTH  = 7;
  localparam int unsigned AP_MAX_WINDOW_HEIGHT = 7;
  localparam int unsigned AP_MAX_STRIDE        = 4;
  localparam int unsigned AP_MAX_TILE_WIDTH    = 32;
  localparam int unsigned AP_MAX_TILE_HEIGHT   = 32;
  localparam int unsigned AP_MAX_PAD           = 3;
  localparam int unsigned AP_CONFIG_ID_WIDTH   = 4;

  localparam int unsigned AP_XW  = $clog2(AP_MAX_TILE_WIDTH + 2 * AP_MAX_PAD + 1);
  localparam int unsigned AP_YW  = $clog2(AP_MAX_TILE_HEIGHT + 2 * AP_MAX_PAD + 1);
  localparam int unsigned AP_WW  = $clog2(AP_MAX_WINDOW_WIDTH + 1);
  localparam int unsigned AP_WH  = $clog2(AP_MAX_WINDOW_HEIGHT + 1);
  localparam int unsigned AP_SW  = $clog2(AP_MAX_STRIDE + 1);
  localparam int unsigned AP_TW  = $clog2(AP_MAX_TILE_WIDTH + 1);
  localparam int unsigned AP_TH  = $clog2(AP_MAX_TILE_HEIGHT + 1);
  localparam int unsigned AP_PW  = $clog2(AP_MAX_PAD + 1);

  typedef struct packed {
    logic [AP_WW-1:0]              window_w;
    logic [AP_WH-1:0]              window_h;
    logic [AP_SW-1:0]              stride_h;
    logic [AP_SW-1:0]              stride_v;
    logic [AP_TW-1:0]              tile_w;
    logic [AP_TH-1:0]              tile_h;
    logic [AP_PW-1:0]              pad_l;
    logic [AP_PW-1:0]              pad_r;
    logic [AP_PW-1:0]              pad_t;
    logic [AP_PW-1:0]              pad_b;
    logic [AP_CONFIG_ID_WIDTH-1:0] config_id;
  } cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sched_state_e;

endpackage

// File: rtl/dla_aux_pool_axis_cnt.sv
// One axis of the padded virtual grid: position, stride phase and pad history.
module dla_aux_pool_axis_cnt
  import dla_aux_pool_pkg::*;
#(
  parameter int unsigned POS_W  = 6,
  parameter int unsigned WIN_W  = 3,
  parameter int unsigned STR_W  = 3,
  parameter int unsigned HIST_W = 7
) (
  input  logic              clk,
  input  logic              i_sclr,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic [POS_W-1:0]  i_pad_lo,
  input  logic [POS_W-1:0]  i_tile_len,
  input  logic [POS_W-1:0]  i_pad_hi,
  input  logic [WIN_W-1:0]  i_window,
  input  logic [STR_W-1:0]  i_stride,
  output logic              o_last,
  output logic              o_is_pad,
  output logic              o_win_ok,
  output logic              o_stride_hit,
  output logic [HIST_W-1:0] o_pad_hist
);

  localparam logic [POS_W:0] POS_ONE_E = (POS_W+1)'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [STR_W:0] STR_ONE_E = (STR_W+1)'(1);
  localparam logic [STR_W-1:0] STR_ONE = STR_W'(1);

  logic [POS_W-1:0]  pos_q, pos_d;
  logic [STR_W-1:0]  scnt_q, scnt_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [POS_W:0]    pos_ext, real_end, span, win_ext;
  logic [HIST_W-1:0] win_mask;
  logic              last, is_pad, win_ok;

  // Decode the current position and compute the next counter state.
  always_comb begin
    pos_ext  = {1'b0, pos_q};
    real_end = {1'b0, i_pad_lo} + {1'b0, i_tile_len};
    span     = real_end + {1'b0, i_pad_hi};
    win_ext  = (POS_W+1)'(i_window);
    last     = (pos_ext + POS_ONE_E) == span;
    is_pad   = (pos_ext < {1'b0, i_pad_lo}) || (pos_ext >= real_end);
    win_ok   = (pos_ext + POS_ONE_E) >= win_ext;
    for (int unsigned k = 0; k < HIST_W; k++) begin
      win_mask[k] = (k < 32'(i_window));
    end

    o_last       = last;
    o_is_pad     = is_pad;
    o_win_ok     = win_ok;
    o_stride_hit = (scnt_q == '0);
    o_pad_hist   = {hist_q[HIST_W-2:0], is_pad} & win_mask;

    pos_d  = pos_q;
    scnt_d = scnt_q;
    hist_d = hist_q;
    if (i_clear) begin
      pos_d  = '0;
      scnt_d = '0;
      hist_d = '0;
    end else if (i_step) begin
      if (last) begin
        pos_d  = '0;
        scnt_d = '0;
        hist_d = '0;
      end else begin
        pos_d  = pos_q + POS_ONE;
        hist_d = {hist_q[HIST_W-2:0], is_pad};
        // Phase stays 0 until the window first fits, then counts modulo stride;
        // a stride of 0 behaves like 1.
        if (!win_ok) begin
          scnt_d = '0;
        end else if (({1'b0, scnt_q} + STR_ONE_E) >= {1'b0, i_stride}) begin
          scnt_d = '0;
        end else begin
          scnt_d = scnt_q + STR_ONE;
        end
      end
    end
  end

  // Axis state registers.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      pos_q  <= '0;
      scnt_q <= '0;
      hist_q <= '0;
    end else begin
      pos_q  <= pos_d;
      scnt_q <= scnt_d;
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/dla_aux_pool_window_sched.sv
// Per-tile pool window sequencer: config handshake, raster walk and registered lane controls.
module dla_aux_pool_window_sched
  import dla_aux_pool_pkg::*;
#(
  parameter int unsigned MAX_WINDOW_WIDTH  = AP_MAX_WINDOW_WIDTH,
  parameter int unsigned MAX_WINDOW_HEIGHT = AP_MAX_WINDOW_HEIGHT,
  parameter int unsigned MAX_STRIDE        = AP_MAX_STRIDE,
  parameter int unsigned MAX_TILE_WIDTH    = AP_MAX_TILE_WIDTH,
  parameter int unsigned MAX_TILE_HEIGHT   = AP_MAX_TILE_HEIGHT,
  parameter int unsigned MAX_PAD           = AP_MAX_PAD,
  parameter int unsigned CONFIG_ID_WIDTH   = AP_CONFIG_ID_WIDTH
) (
  input  logic                         clk,
  input  logic                         i_sclr,
  input  logic                         i_cfg_valid,
  output logic                         o_cfg_ready,
  input  cfg_t                         i_cfg,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic                         i_core_ready,
  output logic                         o_ctl_valid,
  output logic                         o_stride_valid,
  output logic                         o_wait_fill,
  output logic                         o_is_pad_horiz,
  output logic                         o_is_pad_vert,
  output logic [MAX_WINDOW_WIDTH-1:0]  o_pad_horiz,
  output logic [MAX_WINDOW_HEIGHT-1:0] o_pad_vert,
  output logic                         o_line_buff_flush,
  output logic [CONFIG_ID_WIDTH-1:0]   o_config_id,
  output logic                         o_busy
);

  localparam int unsigned XW  = $clog2(MAX_TILE_WIDTH + 2 * MAX_PAD + 1);
  localparam int unsigned YW  = $clog2(MAX_TILE_HEIGHT + 2 * MAX_PAD + 1);
  localparam int unsigned WWW = $clog2(MAX_WINDOW_WIDTH + 1);
  localparam int unsigned WHW = $clog2(MAX_WINDOW_HEIGHT + 1);
  localparam int unsigned SW  = $clog2(MAX_STRIDE + 1);

  sched_state_e state_q, state_d;
  cfg_t         cfg_q, cfg_d;

  logic                         ctl_valid_q, ctl_valid_d;
  logic                         stride_q, stride_d;
  logic                         wait_fill_q, wait_fill_d;
  logic                         is_pad_h_q, is_pad_h_d;
  logic                         is_pad_v_q, is_pad_v_d;
  logic [MAX_WINDOW_WIDTH-1:0]  pad_h_q, pad_h_d;
  logic [MAX_WINDOW_HEIGHT-1:0] pad_v_q, pad_v_d;

  logic accept, advance, pad_zone, y_step;
  logic x_last, x_is_pad, x_win_ok, x_hit;
  logic y_last, y_is_pad, y_win_ok, y_hit;
  logic [MAX_WINDOW_WIDTH-1:0]  x_hist;
  logic [MAX_WINDOW_HEIGHT-1:0] y_hist;

  assign pad_zone = x_is_pad | y_is_pad;
  assign y_step   = advance & x_last;

  dla_aux_pool_axis_cnt #(
    .POS_W  (XW),
    .WIN_W  (WWW),
    .STR_W  (SW),
    .HIST_W (MAX_WINDOW_WIDTH)
  ) u_x_cnt (
    .clk          (clk),
    .i_sclr       (i_sclr),
    .i_clear      (accept),
    .i_step       (advance),
    .i_pad_lo     (XW'(cfg_q.pad_l)),
    .i_tile_len   (XW'(cfg_q.tile_w)),
    .i_pad_hi     (XW'(cfg_q.pad_r)),
    .i_window     (WWW'(cfg_q.window_w)),
    .i_stride     (SW'(cfg_q.stride_h)),
    .o_last       (x_last),
    .o_is_pad     (x_is_pad),
    .o_win_ok     (x_win_ok),
    .o_stride_hit (x_hit),
    .o_pad_hist   (x_hist)
  );

  dla_aux_pool_axis_cnt #(
    .POS_W  (YW),
    .WIN_W  (WHW),
    .STR_W  (SW),
    .HIST_W (MAX_WINDOW_HEIGHT)
  ) u_y_cnt (
    .clk          (clk),
    .i_sclr       (i_sclr),
    .i_clear      (accept),
    .i_step       (y_step),
    .i_pad_lo     (YW'(cfg_q.pad_t)),
    .i_tile_len   (YW'(cfg_q.tile_h)),
    .i_pad_hi     (YW'(cfg_q.pad_b)),
    .i_window     (WHW'(cfg_q.window_h)),
    .i_stride     (SW'(cfg_q.stride_v)),
    .o_last       (y_last),
    .o_is_pad     (y_is_pad),
    .o_win_ok     (y_win_ok),
    .o_stride_hit (y_hit),
    .o_pad_hist   (y_hist)
  );

  // FSM next state, handshake and step qualification.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    advance     = 1'b0;
    o_in_ready  = 1'b0;
    o_cfg_ready = 1'b0;
    case (state_q)
      IDLE: begin
        o_cfg_ready = 1'b1;
        if (i_cfg_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        o_in_ready = i_core_ready & ~pad_zone;
        advance    = i_core_ready & (pad_zone | i_in_valid);
        if (advance && x_last && y_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Config latch and per-step output fields; fields hold between steps.
  always_comb begin
    cfg_d       = accept ? i_cfg : cfg_q;
    ctl_valid_d = advance;
    stride_d    = stride_q;
    wait_fill_d = wait_fill_q;
    is_pad_h_d  = is_pad_h_q;
    is_pad_v_d  = is_pad_v_q;
    pad_h_d     = pad_h_q;
    pad_v_d     = pad_v_q;
    if (advance) begin
      stride_d    = x_win_ok & y_win_ok & x_hit & y_hit;
      wait_fill_d = ~y_win_ok;
      is_pad_h_d  = x_is_pad;
      is_pad_v_d  = y_is_pad;
      pad_h_d     = x_hist;
      pad_v_d     = y_hist;
    end
  end

  // State, config and output registers.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      ctl_valid_q <= 1'b0;
      stride_q    <= 1'b0;
      wait_fill_q <= 1'b0;
      is_pad_h_q  <= 1'b0;
      is_pad_v_q  <= 1'b0;
      pad_h_q     <= '0;
      pad_v_q     <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      ctl_valid_q <= ctl_valid_d;
      stride_q    <= stride_d;
      wait_fill_q <= wait_fill_d;
      is_pad_h_q  <= is_pad_h_d;
      is_pad_v_q  <= is_pad_v_d;
      pad_h_q     <= pad_h_d;
      pad_v_q     <= pad_v_d;
    end
  end

  assign o_ctl_valid       = ctl_valid_q;
  assign o_stride_valid    = stride_q;
  assign o_wait_fill       = wait_fill_q;
  assign o_is_pad_horiz    = is_pad_h_q;
  assign o_is_pad_vert     = is_pad_v_q;
  assign o_pad_horiz       = pad_h_q;
  assign o_pad_vert        = pad_v_q;
  assign o_line_buff_flush = (state_q == FLUSH);
  assign o_config_id       = CONFIG_ID_WIDTH'(cfg_q.config_id);
  assign o_busy            = (state_q != IDLE);

endmodule

// File: tb/tb_dla_aux_pool_window_sched.sv
// Self-checking bench for the aux pool window scheduler.
module tb_dla_aux_pool_window_sched;
  import dla_aux_pool_pkg::*;

  logic       clk = 1'b0;
  logic       i_sclr, i_cfg_valid, i_in_valid, i_core_ready;
  cfg_t       i_cfg;
  logic       o_cfg_ready, o_in_ready, o_ctl_valid, o_stride_valid, o_wait_fill;
  logic       o_is_pad_horiz, o_is_pad_vert, o_line_buff_flush, o_busy;
  logic [6:0] o_pad_horiz, o_pad_vert;
  logic [3:0] o_config_id;

  always #5 clk = ~clk;

  dla_aux_pool_window_sched dut (
    .clk               (clk),
    .i_sclr            (i_sclr),
    .i_cfg_valid       (i_cfg_valid),
    .o_cfg_ready       (o_cfg_ready),
    .i_cfg             (i_cfg),
    .i_in_valid        (i_in_valid),
    .o_in_ready        (o_in_ready),
    .i_core_ready      (i_core_ready),
    .o_ctl_valid       (o_ctl_valid),
    .o_stride_valid    (o_stride_valid),
    .o_wait_fill       (o_wait_fill),
    .o_is_pad_horiz    (o_is_pad_horiz),
    .o_is_pad_vert     (o_is_pad_vert),
    .o_pad_horiz       (o_pad_horiz),
    .o_pad_vert        (o_pad_vert),
    .o_line_buff_flush (o_line_buff_flush),
    .o_config_id       (o_config_id),
    .o_busy            (o_busy)
  );

  typedef struct {
    logic       sv;
    logic       wf;
    logic       ph;
    logic       pv;
    logic [6:0] phv;
    logic [6:0] pvv;
  } step_t;

  typedef struct {
    cfg_t c;
    int   steps;
    int   beats;
    int   svs;
  } vec_t;

  step_t       exp_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic cfg_t mk_cfg(input int ww, wh, sh, sv, tw, th, pl, pr, pt, pb, id);
    cfg_t c;
    c.window_w  = AP_WW'(ww);
    c.window_h  = AP_WH'(wh);
    c.stride_h  = AP_SW'(sh);
    c.stride_v  = AP_SW'(sv);
    c.tile_w    = AP_TW'(tw);
    c.tile_h    = AP_TH'(th);
    c.pad_l     = AP_PW'(pl);
    c.pad_r     = AP_PW'(pr);
    c.pad_t     = AP_PW'(pt);
    c.pad_b     = AP_PW'(pb);
    c.config_id = AP_CONFIG_ID_WIDTH'(id);
    return c;
  endfunction

  function automatic bit in_pad(input int p, input int lo, input int len);
    return (p < lo) || (p >= lo + len);
  endfunction

  // Reference: enumerate every virtual grid step directly from the geometry rules.
  task automatic build_model(input cfg_t c);
    int ww, wh, sh, sv, tw, th, pl, pt, vw, vh;
    ww = int'(c.window_w); wh = int'(c.window_h);
    sh = int'(c.stride_h); sv = int'(c.stride_v);
    tw = int'(c.tile_w);   th = int'(c.tile_h);
    pl = int'(c.pad_l);    pt = int'(c.pad_t);
    vw = pl + tw + int'(c.pad_r);
    vh = pt + th + int'(c.pad_b);
    exp_q.delete();
    for (int y = 0; y < vh; y++) begin
      for (int x = 0; x < vw; x++) begin
        step_t s;
        s.ph = in_pad(x, pl, tw);
        s.pv = in_pad(y, pt, th);
        s.wf = (y < wh - 1);
        s.sv = (x >= ww - 1) && (y >= wh - 1) &&
               (((x - (ww - 1)) % sh) == 0) && (((y - (wh - 1)) % sv) == 0);
        for (int k = 0; k < 7; k++) begin
          s.phv[k] = (k < ww && x - k >= 0) ? in_pad(x - k, pl, tw) : 1'b0;
          s.pvv[k] = (k < wh && y - k >= 0) ? in_pad(y - k, pt, th) : 1'b0;
        end
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl_valid"}, 32'(o_ctl_valid), 0);
    chk({tag, "_stride_valid"}, 32'(o_stride_valid), 0);
    chk({tag, "_wait_fill"}, 32'(o_wait_fill), 0);
    chk({tag, "_is_pad_h"}, 32'(o_is_pad_horiz), 0);
    chk({tag, "_is_pad_v"}, 32'(o_is_pad_vert), 0);
    chk({tag, "_pad_h"}, 32'(o_pad_horiz), 0);
    chk({tag, "_pad_v"}, 32'(o_pad_vert), 0);
    chk({tag, "_flush"}, 32'(o_line_buff_flush), 0);
    chk({tag, "_config_id"}, 32'(o_config_id), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_cfg_ready"}, 32'(o_cfg_ready), 1);
    chk({tag, "_in_ready"}, 32'(o_in_ready), 0);
  endtask

  // Runs one tile and compares every cycle against the model.
  task automatic run_tile(input cfg_t c, input bit rnd, input bit hold, input cfg_t hcfg,
                          input bit skip_acc, input int cap_idx,
                          output int steps, output int beats, output int svs,
                          output logic [6:0] cap_ph, output logic [6:0] cap_pv);
    int n, idx, pidx, cyc, budget;
    bit padv, core, inv, pad;
    build_model(c);
    n = exp_q.size();
    budget = 6 * n + 64;
    idx = 0; pidx = 0; cyc = 0; padv = 0;
    steps = 0; beats = 0; svs = 0; cap_ph = '0; cap_pv = '0;
    if (!skip_acc) begin
      @(negedge clk);
      i_cfg = c; i_cfg_valid = 1'b1; i_core_ready = 1'b0; i_in_valid = 1'b0;
      #1 chk("cfg_ready_idle", 32'(o_cfg_ready), 1);
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (hold) begin
        i_cfg = hcfg; i_cfg_valid = 1'b1;
      end else begin
        i_cfg_valid = 1'b0;
      end
      chk("ctl_valid", 32'(o_ctl_valid), 32'(padv));
      if (o_ctl_valid) steps++;
      if (padv) begin
        chk("stride_valid", 32'(o_stride_valid), 32'(exp_q[pidx].sv));
        chk("wait_fill", 32'(o_wait_fill), 32'(exp_q[pidx].wf));
        chk("is_pad_horiz", 32'(o_is_pad_horiz), 32'(exp_q[pidx].ph));
        chk("is_pad_vert", 32'(o_is_pad_vert), 32'(exp_q[pidx].pv));
        chk("pad_horiz", 32'(o_pad_horiz), 32'(exp_q[pidx].phv));
        chk("pad_vert", 32'(o_pad_vert), 32'(exp_q[pidx].pvv));
        if (o_stride_valid) svs++;
        if (pidx == cap_idx) begin
          cap_ph = o_pad_horiz;
          cap_pv = o_pad_vert;
        end
      end
      chk("flush", 32'(o_line_buff_flush), 32'(padv && pidx == n - 1));
      chk("config_id", 32'(o_config_id), 32'(c.config_id));
      if (padv && pidx == n - 1) break;
      chk("cfg_ready_busy", 32'(o_cfg_ready), 0);
      if (cyc >= budget) begin
        chk("step_budget", 32'(idx), 32'(n));
        break;
      end
      core = rnd ? ($urandom_range(3) != 0) : 1'b1;
      inv  = rnd ? ($urandom_range(2) != 0) : 1'b1;
      i_core_ready = core;
      i_in_valid   = inv;
      pad = exp_q[idx].ph | exp_q[idx].pv;
      #1 chk("in_ready", 32'(o_in_ready), 32'(core & ~pad));
      if (o_in_ready && inv) beats++;
      padv = core & (pad | inv);
      if (padv) begin
        pidx = idx;
        idx++;
      end
      cyc++;
    end
    i_core_ready = 1'b1;
    i_in_valid   = 1'b1;
    #1;
    chk("in_ready_flush", 32'(o_in_ready), 0);
    chk("busy_flush", 32'(o_busy), 1);
    @(negedge clk);
    chk("cfg_ready_after", 32'(o_cfg_ready), 1);
    chk("busy_after", 32'(o_busy), 0);
    chk("flush_after", 32'(o_line_buff_flush), 0);
    chk("ctl_valid_after", 32'(o_ctl_valid), 0);
    chk("config_id_after", 32'(o_config_id), 32'(c.config_id));
    i_core_ready = 1'b0;
    i_in_valid   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[6];
    cfg_t       none;
    int         st, bt, sv;
    logic [6:0] cph, cpv;

    none = '0;
    vecs[0] = '{mk_cfg(2, 2, 2, 2, 4, 4, 0, 0, 0, 0, 1), 16, 16, 4};
    vecs[1] = '{mk_cfg(3, 3, 1, 1, 3, 3, 1, 1, 1, 1, 2), 25, 9, 9};
    vecs[2] = '{mk_cfg(5, 1, 4, 1, 13, 1, 0, 0, 0, 0, 3), 13, 13, 3};
    vecs[3] = '{mk_cfg(1, 1, 1, 1, 5, 3, 0, 0, 0, 0, 4), 15, 15, 15};
    vecs[4] = '{mk_cfg(3, 2, 2, 3, 6, 7, 2, 0, 3, 1, 5), 88, 42, 12};
    vecs[5] = '{mk_cfg(7, 7, 4, 4, 32, 32, 3, 3, 3, 3, 6), 1444, 1024, 64};

    i_sclr = 1'b1; i_cfg_valid = 1'b0; i_in_valid = 1'b0; i_core_ready = 1'b0; i_cfg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    i_sclr = 1'b0;

    // Deterministic table of tiles.
    for (int i = 0; i < 6; i++) begin
      run_tile(vecs[i].c, 1'b0, 1'b0, none, 1'b0, 12, st, bt, sv, cph, cpv);
      chk($sformatf("v%0d_steps", i), 32'(st), 32'(vecs[i].steps));
      chk($sformatf("v%0d_beats", i), 32'(bt), 32'(vecs[i].beats));
      chk($sformatf("v%0d_stride_count", i), 32'(sv), 32'(vecs[i].svs));
      if (i == 1) begin
        chk("pad_horiz_at_2_2", 32'(cph), 32'h4);
        chk("pad_vert_at_2_2", 32'(cpv), 32'h4);
      end
    end

    // Random stalls and input gaps on the padded and asymmetric cases.
    for (int r = 0; r < 3; r++) begin
      run_tile(vecs[1].c, 1'b1, 1'b0, none, 1'b0, -1, st, bt, sv, cph, cpv);
      chk("rnd_v1_steps", 32'(st), 25);
      chk("rnd_v1_beats", 32'(bt), 9);
      chk("rnd_v1_stride_count", 32'(sv), 9);
    end
    run_tile(vecs[4].c, 1'b1, 1'b0, none, 1'b0, -1, st, bt, sv, cph, cpv);
    chk("rnd_v4_steps", 32'(st), 88);
    chk("rnd_v4_stride_count", 32'(sv), 12);

    // Config offered throughout a tile is taken only once the tile has flushed.
    run_tile(mk_cfg(2, 2, 2, 2, 4, 4, 0, 0, 0, 0, 7), 1'b0, 1'b1,
             mk_cfg(5, 1, 4, 1, 13, 1, 0, 0, 0, 0, 9), 1'b0, -1, st, bt, sv, cph, cpv);
    chk("hold_first_steps", 32'(st), 16);
    run_tile(mk_cfg(5, 1, 4, 1, 13, 1, 0, 0, 0, 0, 9), 1'b1, 1'b0, none, 1'b1, -1,
             st, bt, sv, cph, cpv);
    chk("hold_second_steps", 32'(st), 13);
    chk("hold_second_stride_count", 32'(sv), 3);

    // Reset in the middle of a tile abandons it without a flush.
    @(negedge clk);
    i_cfg = mk_cfg(2, 2, 2, 2, 4, 4, 0, 0, 0, 0, 10);
    i_cfg_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_cfg_valid = 1'b0; i_core_ready = 1'b1; i_in_valid = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("midtile_ctl_valid", 32'(o_ctl_valid), 1);
    chk("midtile_busy", 32'(o_busy), 1);
    i_sclr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("sclr_mid");
    i_sclr = 1'b0;
    @(negedge clk);
    chk("sclr_no_flush", 32'(o_line_buff_flush), 0);
    i_core_ready = 1'b0; i_in_valid = 1'b0;
    run_tile(vecs[1].c, 1'b0, 1'b0, none, 1'b0, 12, st, bt, sv, cph, cpv);
    chk("post_sclr_steps", 32'(st), 25);
    chk("post_sclr_beats", 32'(bt), 9);
    chk("post_sclr_pad_horiz_at_2_2", 32'(cph), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
